// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the MEM-stage data memory.
// Size codes, FSM states, alignment and lane-select functions.
package data_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS
  } state_t;

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    logic bad;
    bad = 1'b1;
    unique case (1'b1)
      size == SIZE_BYTE: bad = 1'b0;
      size == SIZE_HALF: bad = lo[0];
      size == SIZE_WORD: bad = |lo;
      default:           bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_mask(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    logic [3:0] m;
    m = 4'b0000;
    unique case (1'b1)
      size == SIZE_BYTE: m = 4'b0001 << lo;
      size == SIZE_HALF: m = lo[1] ? 4'b1100 : 4'b0011;
      size == SIZE_WORD: m = 4'b1111;
      default:           m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/data_memory_unit_if.sv
// Request/response bundle between the MEM stage and data memory.
// The master drives requests; the slave answers with ready/done.
interface data_memory_unit_if;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] address_input;
  logic [31:0] write_data;
  logic        req_ready;
  logic        stall;
  logic [31:0] data_output;
  logic        done;
  logic        addr_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned,
    output address_input, write_data,
    input  req_ready, stall, data_output, done, addr_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned,
    input  address_input, write_data,
    output req_ready, stall, data_output, done, addr_err
  );
endinterface

// File: rtl/dmem_lane_array.sv
// Word-organised byte-lane storage: per-lane write enables and a
// registered full-word read port. Contents are never reset.
module dmem_lane_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [7:0] mem [DEPTH_WORDS][4];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[waddr][i] <= wdata[8*i +: 8];
    end
    rdata <= {mem[raddr][3], mem[raddr][2],
              mem[raddr][1], mem[raddr][0]};
  end

endmodule

// File: rtl/data_memory_unit.sv
// MEM-stage data memory: byte/half/word access with wait states,
// stall handshake, load extension and alignment/range faults.
module data_memory_unit
  import data_mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input logic               clk,
  input logic               rst_n,
  data_memory_unit_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] CNT_INIT =
    (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  state_t state, state_nxt;
  logic [2:0] cnt, cnt_nxt;

  logic              wr_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] dout;
  logic              done_q;
  logic              err_q;

  logic        accept;
  logic        in_access;
  logic        fault;
  logic [3:0]  we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] shifted;
  logic [31:0] load_val;
  logic [AW-1:0] raddr;

  assign accept    = (state == IDLE) && bus.req_valid;
  assign in_access = (state == ACCESS);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (WAIT_STATES > 0) ? WAIT : ACCESS;
          cnt_nxt   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt == 3'd0) state_nxt = ACCESS;
        else cnt_nxt = cnt - 3'd1;
      end
      ACCESS:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= 1'b0;
      size_q <= SIZE_BYTE;
      uns_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (accept) begin
      wr_q   <= bus.req_write;
      size_q <= bus.req_size;
      uns_q  <= bus.req_unsigned;
      addr_q <= bus.address_input;
      data_q <= bus.write_data;
    end
  end

  assign fault = misaligned(size_q, addr_q[1:0])
               | (|addr_q[31:AW+2]);

  always_comb begin
    we = 4'b0000;
    if (in_access && wr_q && !fault)
      we = lane_mask(size_q, addr_q[1:0]);
  end

  always_comb begin
    wdata = data_q;
    unique case (1'b1)
      size_q == SIZE_BYTE: wdata = {4{data_q[7:0]}};
      size_q == SIZE_HALF: wdata = {2{data_q[15:0]}};
      default:             wdata = data_q;
    endcase
  end

  // In IDLE the read port follows the incoming address so the word
  // is already registered when a zero-wait access reaches ACCESS.
  assign raddr = (state == IDLE) ? bus.address_input[AW+1:2]
                                 : addr_q[AW+1:2];

  dmem_lane_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_lanes (
    .clk   (clk),
    .we    (we),
    .waddr (addr_q[AW+1:2]),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  assign shifted = rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_val = shifted;
    unique case (1'b1)
      size_q == SIZE_BYTE:
        load_val = uns_q ? {24'b0, shifted[7:0]}
                         : {{24{shifted[7]}}, shifted[7:0]};
      size_q == SIZE_HALF:
        load_val = uns_q ? {16'b0, shifted[15:0]}
                         : {{16{shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout   <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= in_access;
      err_q  <= in_access && fault;
      if (in_access && !wr_q && !fault) dout <= load_val;
    end
  end

  assign bus.req_ready   = (state == IDLE);
  assign bus.stall       = (state != IDLE);
  assign bus.data_output = dout;
  assign bus.done        = done_q;
  assign bus.addr_err    = err_q;

endmodule

// File: tb/tb_data_memory_unit.sv
// Bench for data_memory_unit: a zero-wait and a one-wait instance
// checked against a byte-addressed reference model.
module tb_data_memory_unit;

  localparam int DEPTH = 64;
  localparam int NBYTE = 4 * DEPTH;

  logic        clk;
  logic        rst_n;
  logic        v;
  logic        wr;
  logic [1:0]  sz;
  logic        un;
  logic [31:0] ad;
  logic [31:0] wdat;
  int          sel;

  logic        rdy, st, dn, ae;
  logic [31:0] dout;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  ref_mem [2][NBYTE];
  logic [31:0] exp_dout [2];

  data_memory_unit_if b0 ();
  data_memory_unit_if b1 ();

  assign b0.req_valid     = v && (sel == 0);
  assign b1.req_valid     = v && (sel == 1);
  assign b0.req_write     = wr;
  assign b1.req_write     = wr;
  assign b0.req_size      = sz;
  assign b1.req_size      = sz;
  assign b0.req_unsigned  = un;
  assign b1.req_unsigned  = un;
  assign b0.address_input = ad;
  assign b1.address_input = ad;
  assign b0.write_data    = wdat;
  assign b1.write_data    = wdat;

  data_memory_unit #(
    .DATA_W (32), .DEPTH_WORDS (DEPTH), .WAIT_STATES (0)
  ) dut0 (
    .clk (clk), .rst_n (rst_n), .bus (b0)
  );

  data_memory_unit #(
    .DATA_W (32), .DEPTH_WORDS (DEPTH), .WAIT_STATES (1)
  ) dut1 (
    .clk (clk), .rst_n (rst_n), .bus (b1)
  );

  always_comb begin
    if (sel == 1) begin
      rdy = b1.req_ready; st = b1.stall; dn = b1.done;
      ae = b1.addr_err; dout = b1.data_output;
    end else begin
      rdy = b0.req_ready; st = b0.stall; dn = b0.done;
      ae = b0.addr_err; dout = b0.data_output;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: bytes addressed directly, little-endian assembly.
  function automatic bit model(int s, bit w, logic [1:0] z, bit u,
                               logic [31:0] a, logic [31:0] d);
    int nb;
    bit f;
    logic [31:0] val;
    nb = 1 << z;
    f = (z == 2'd3) || ((a % nb) != 0) || (a >= NBYTE);
    if (!f) begin
      if (w) begin
        for (int i = 0; i < nb; i++) ref_mem[s][a+i] = d[8*i +: 8];
      end else begin
        val = 0;
        for (int i = 0; i < nb; i++)
          val = val | (32'(ref_mem[s][a+i]) << (8*i));
        if (nb < 4 && !u && val[8*nb-1])
          val = val | (32'hFFFF_FFFF << (8*nb));
        exp_dout[s] = val;
      end
    end
    return f;
  endfunction

  task automatic op(int s, bit w, logic [1:0] z, bit u,
                    logic [31:0] a, logic [31:0] d);
    int n;
    int lat;
    bit e;
    lat = (s == 1) ? 2 : 1;
    @(negedge clk);
    sel = s; wr = w; sz = z; un = u; ad = a; wdat = d; v = 1'b1;
    check("ready_idle", rdy, 1);
    @(posedge clk);
    #1 v = 1'b0;
    e = model(s, w, z, u, a, d);
    n = 0;
    while (!dn && n < 20) begin
      check("stall_busy", st, 1);
      @(posedge clk);
      #1 n++;
    end
    check("latency", n, lat);
    check("addr_err", ae, e);
    check("data_output", dout, exp_dout[s]);
    check("ready_done", rdy, 1);
    @(posedge clk);
    #1 check("done_pulse", dn, 0);
  endtask

  task automatic rand_req();
    sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    ad = $urandom_range(0, NBYTE + 7);
    if ($urandom_range(0, 3) != 0 && sz != 2'd3)
      ad = ad & ~((32'd1 << sz) - 32'd1);
    wr = 1'($urandom_range(0, 1));
    un = 1'($urandom_range(0, 1));
    wdat = $urandom;
  endtask

  initial begin
    bit e_prev;
    rst_n = 1'b0; v = 1'b0; wr = 1'b0; sz = 2'd0; un = 1'b0;
    ad = '0; wdat = '0; sel = 1;
    exp_dout[0] = '0; exp_dout[1] = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      check("rst_dout", dout, 0);
      check("rst_done", dn, 0);
      check("rst_err", ae, 0);
      check("rst_ready", rdy, 1);
      check("rst_stall", st, 0);
    end
    rst_n = 1'b1;

    for (int s = 0; s < 2; s++)
      for (int w = 0; w < DEPTH; w++)
        op(s, 1'b1, 2'd2, 1'b0, 32'(4*w), $urandom);

    op(1, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
    op(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    check("word_load", dout, 32'hDEAD_BEEF);

    op(1, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0);
    op(1, 1'b1, 2'd0, 1'b0, 32'h21, 32'h7F);
    op(1, 1'b1, 2'd0, 1'b0, 32'h22, 32'h80);
    op(1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    check("byte_lanes", dout, 32'h0080_7F00);
    op(1, 1'b0, 2'd0, 1'b0, 32'h22, 32'h0);
    check("lb", dout, 32'hFFFF_FF80);
    op(1, 1'b0, 2'd0, 1'b1, 32'h22, 32'h0);
    check("lbu", dout, 32'h0000_0080);

    op(1, 1'b1, 2'd2, 1'b0, 32'h30, 32'h1122_3344);
    op(1, 1'b1, 2'd1, 1'b0, 32'h32, 32'h8001);
    op(1, 1'b0, 2'd1, 1'b0, 32'h32, 32'h0);
    check("lh", dout, 32'hFFFF_8001);
    op(1, 1'b0, 2'd1, 1'b1, 32'h32, 32'h0);
    check("lhu", dout, 32'h0000_8001);
    op(1, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0);
    check("half_lanes", dout, 32'h8001_3344);

    op(1, 1'b0, 2'd2, 1'b0, 32'h13, 32'h0);
    check("flt_word_hold", dout, 32'h8001_3344);
    op(1, 1'b1, 2'd1, 1'b0, 32'h41, 32'h5555);
    op(1, 1'b0, 2'd2, 1'b0, NBYTE, 32'h0);
    check("flt_range_hold", dout, 32'h8001_3344);
    op(1, 1'b1, 2'd3, 1'b0, 32'h10, 32'h0);
    op(1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    op(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    check("flt_no_write", dout, 32'hDEAD_BEEF);

    for (int i = 0; i < 200; i++) begin
      rand_req();
      op(int'($urandom_range(0, 1)), wr, sz, un, ad, wdat);
    end

    @(negedge clk);
    sel = 0;
    rand_req();
    v = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check("b2b_ready", rdy, 1);
      check("b2b_stall", st, 0);
      if (k > 0) begin
        check("b2b_done", dn, 1);
        check("b2b_err", ae, e_prev);
        check("b2b_dout", dout, exp_dout[0]);
      end
      e_prev = model(0, wr, sz, un, ad, wdat);
      @(posedge clk);
      #1;
      if (k < 5) rand_req();
      else v = 1'b0;
      @(negedge clk);
      check("b2b_busy", rdy, 0);
      check("b2b_done_lo", dn, 0);
      @(negedge clk);
    end
    check("b2b_done_last", dn, 1);
    check("b2b_err_last", ae, e_prev);
    check("b2b_dout_last", dout, exp_dout[0]);

    op(1, 1'b1, 2'd2, 1'b0, 32'h50, 32'hCAFE_F00D);
    op(1, 1'b1, 2'd2, 1'b0, 32'h60, 32'h1234_5678);
    op(1, 1'b0, 2'd2, 1'b0, 32'h60, 32'h0);
    @(negedge clk);
    sel = 1; wr = 1'b1; sz = 2'd2; un = 1'b0;
    ad = 32'h50; wdat = 32'h0BAD_BEEF; v = 1'b1;
    @(posedge clk);
    #1 v = 1'b0;
    check("pre_rst_stall", st, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_dout", dout, 0);
    check("arst_done", dn, 0);
    check("arst_err", ae, 0);
    check("arst_ready", rdy, 1);
    exp_dout[0] = '0;
    exp_dout[1] = '0;
    repeat (2) begin
      @(posedge clk);
      #1 check("arst_no_done", dn, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    op(1, 1'b0, 2'd2, 1'b0, 32'h50, 32'h0);
    check("arst_no_write", dout, 32'hCAFE_F00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
